kamus_wb_arbiter: RTL and testbench



---
 rtl/kamus_wb_arbiter_if.sv | 26 ++
 rtl/kamus_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_kamus_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kamus_wb_arbiter_if.sv
// Writeback request/response bundle between the producers and kamus_wb_arbiter.
// The slave modport is the arbiter side; master is the producer/register-file side.
interface kamus_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*5-1:0]      req_rd_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic                      rf_we_o;
  logic [4:0]                rf_rd_addr_o;
  logic [DATA_W-1:0]         rf_wr_data_o;
  logic [1:0]                rf_grant_id_o;
  logic                      busy_o;

  modport slave (
    input  req_valid_i, req_rd_i, req_data_i,
    output req_ready_o, rf_we_o, rf_rd_addr_o, rf_wr_data_o, rf_grant_id_o, busy_o
  );

  modport master (
    output req_valid_i, req_rd_i, req_data_i,
    input  req_ready_o, rf_we_o, rf_rd_addr_o, rf_wr_data_o, rf_grant_id_o, busy_o
  );
endinterface

// File: rtl/kamus_wb_arbiter.sv
// Writeback arbiter: one holding buffer per producer, one register-file write per cycle.
// Define KAMUS_WB_RR_EN for round-robin; default is fixed priority with starvation promotion.
module kamus_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  kamus_wb_arbiter_if.slave wb
);

  logic [NUM_REQ-1:0] buf_valid;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] accept;
  logic [4:0]         buf_rd   [NUM_REQ];
  logic [DATA_W-1:0]  buf_data [NUM_REQ];
  logic               grant_any;
  logic [1:0]         grant_id;
  logic [4:0]         sel_rd;
  logic [DATA_W-1:0]  sel_data;

`ifdef KAMUS_WB_RR_EN
  logic [1:0] ptr;

  // Scan from ptr upward with wrap-around; the first valid entry wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && buf_valid[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k - NUM_REQ == i))) begin
          grant[i]  = 1'b1;
          grant_id  = 2'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
    end
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]      starve [NUM_REQ];
  logic [NUM_REQ-1:0] starved;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = buf_valid[i] && (starve[i] == SW'(STARVE_MAX));
    end
  end

  // Starved entries pre-empt fixed priority; ties inside each class go to the lowest index.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && starved[i]) begin
        grant[i]  = 1'b1;
        grant_id  = 2'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && buf_valid[i]) begin
        grant[i]  = 1'b1;
        grant_id  = 2'(i);
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) starve[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] || !buf_valid[i]) begin
          starve[i] <= '0;
        end else if (starve[i] != SW'(STARVE_MAX)) begin
          starve[i] <= starve[i] + 1'b1;
        end
      end
    end
  end
`endif

  assign ready          = ~buf_valid | grant;
  assign accept         = wb.req_valid_i & ready;
  assign wb.req_ready_o = ready;
  assign wb.busy_o      = |buf_valid;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = buf_rd[i];
        sel_data = buf_data[i];
      end
    end
  end

  // A write to x0 is accepted but never buffered, so it can never reach the register file.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          buf_rd[i]    <= wb.req_rd_i[5*i +: 5];
          buf_data[i]  <= wb.req_data_i[DATA_W*i +: DATA_W];
          buf_valid[i] <= (wb.req_rd_i[5*i +: 5] != 5'd0);
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb.rf_we_o       <= 1'b0;
      wb.rf_rd_addr_o  <= '0;
      wb.rf_wr_data_o  <= '0;
      wb.rf_grant_id_o <= '0;
    end else begin
      wb.rf_we_o <= grant_any;
      if (grant_any) begin
        wb.rf_rd_addr_o  <= sel_rd;
        wb.rf_wr_data_o  <= sel_data;
        wb.rf_grant_id_o <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_kamus_wb_arbiter.sv
// Self-checking bench for kamus_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the writeback rules.
module tb_kamus_wb_arbiter;

  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kamus_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) wb();

  kamus_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb)
  );

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // Behavioural model: pending entry per producer and how long it has been passed over.
  bit          m_valid [N];
  logic [4:0]  m_rd    [N];
  logic [31:0] m_data  [N];
  int          m_wait  [N];
  bit          m_acc   [N];
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_gid;

  function automatic int pick();
`ifdef KAMUS_WB_RR_EN
    for (int k = 0; k < N; k++) begin
      if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
`else
    for (int i = 0; i < N; i++) if (m_valid[i] && m_wait[i] >= SMAX) return i;
    for (int i = 0; i < N; i++) if (m_valid[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_wait[i]  = 0;
      m_acc[i]   = 1'b0;
    end
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_gid = '0;
  endtask

  task automatic model_step();
    int g;
    bit rdy;
    logic [4:0] nrd;
    if (rst) begin
      model_reset();
      return;
    end
    g = pick();
    m_we = (g >= 0);
    if (g >= 0) begin
      m_addr  = m_rd[g];
      m_wdata = m_data[g];
      m_gid   = 2'(g);
      m_ptr   = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      rdy      = !m_valid[i] || (g == i);
      m_acc[i] = wb.req_valid_i[i] && rdy;
      if (g == i || !m_valid[i]) m_wait[i] = 0;
      else m_wait[i] = (m_wait[i] + 1 > SMAX) ? SMAX : m_wait[i] + 1;
      nrd = wb.req_rd_i[5*i +: 5];
      if (m_acc[i]) begin
        m_valid[i] = (nrd != 5'd0);
        m_rd[i]    = nrd;
        m_data[i]  = wb.req_data_i[32*i +: 32];
      end else if (g == i) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int g = pick();
    logic [N-1:0] er;
    bit busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      er[i] = !m_valid[i] || (g == i);
      busy  = busy | m_valid[i];
    end
    chk("ready", 32'(wb.req_ready_o), 32'(er));
    chk("busy", 32'(wb.busy_o), 32'(busy));
    chk("rf_we", 32'(wb.rf_we_o), 32'(m_we));
    chk("rf_addr", 32'(wb.rf_rd_addr_o), 32'(m_addr));
    chk("rf_data", wb.rf_wr_data_o, m_wdata);
    chk("rf_gid", 32'(wb.rf_grant_id_o), 32'(m_gid));
  endtask

  task automatic cycle();
    @(negedge clk);
    if (checking) checkOutput();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v,
                               input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    wb.req_valid_i = v;
    wb.req_rd_i    = {r2, r1, r0};
    wb.req_data_i  = {d2, d1, d0};
  endtask

  // Producers in mask present writes back to back, holding anything not yet accepted.
  task automatic streamInputs(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        wb.req_valid_i[i] = 1'b0;
      end else if (!wb.req_valid_i[i] || m_acc[i]) begin
        wb.req_valid_i[i]        = 1'b1;
        wb.req_rd_i[5*i +: 5]    = 5'($urandom_range(1, 31));
        wb.req_data_i[32*i +: 32] = $urandom;
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    cycle();
    cycle();
    rst = 1'b0;
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    checking = 1'b1;
    chk("rst_we", 32'(wb.rf_we_o), 32'd0);
    chk("rst_busy", 32'(wb.busy_o), 32'd0);
    chk("rst_ready", 32'(wb.req_ready_o), 32'd7);
    chk("rst_gid", 32'(wb.rf_grant_id_o), 32'd0);

    // Single ALU write shows up two cycles after acceptance, for one cycle only.
    applyStimulus(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
    cycle();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("single_we", 32'(wb.rf_we_o), 32'd1);
    chk("single_addr", 32'(wb.rf_rd_addr_o), 32'd5);
    chk("single_data", wb.rf_wr_data_o, 32'hDEADBEEF);
    chk("single_gid", 32'(wb.rf_grant_id_o), 32'd1);
    cycle();
    chk("single_we_off", 32'(wb.rf_we_o), 32'd0);

    // Write to x0 is accepted and silently dropped.
    applyStimulus(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0);
    chk("x0_ready", 32'(wb.req_ready_o[0]), 32'd1);
    cycle();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("x0_busy", 32'(wb.busy_o), 32'd0);
    cycle();
    chk("x0_we", 32'(wb.rf_we_o), 32'd0);
    cycle();
    chk("x0_we2", 32'(wb.rf_we_o), 32'd0);

`ifndef KAMUS_WB_RR_EN
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
    cycle();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("conflict_gid", 32'(wb.rf_grant_id_o), 32'(k));
      chk("conflict_addr", 32'(wb.rf_rd_addr_o), 32'(k + 1));
      cycle();
    end
    chk("conflict_we_off", 32'(wb.rf_we_o), 32'd0);

    // LSU streams while ALU holds one entry; ALU must win on its 5th buffered cycle.
    applyStimulus(3'b011, 5'd7, 5'd9, 5'd0, 32'h100, 32'h99, 32'h0);
    cycle();
    for (int c = 1; c <= 6; c++) begin
      if (c >= 2) begin
        chk("starve_we", 32'(wb.rf_we_o), 32'd1);
        chk("starve_gid", 32'(wb.rf_grant_id_o), (c == 6) ? 32'd1 : 32'd0);
      end
      streamInputs(3'b001);
      cycle();
    end
    chk("starve_resume", 32'(wb.rf_grant_id_o), 32'd0);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    repeat (4) cycle();
`else
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) chk("rr_gid", 32'(wb.rf_grant_id_o), 32'((c - 2) % 3));
      streamInputs(3'b111);
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rr_rst_we", 32'(wb.rf_we_o), 32'd0);
    chk("rr_rst_busy", 32'(wb.busy_o), 32'd0);
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) chk("rr_restart_gid", 32'(wb.rf_grant_id_o), 32'((c - 2) % 3));
      streamInputs(3'b111);
      cycle();
    end
`endif

    // Random traffic with occasional resets, obeying the hold-while-stalled rule.
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(wb.req_valid_i[i] && !m_acc[i])) begin
          wb.req_valid_i[i]         = ($urandom_range(0, 99) < 60);
          wb.req_rd_i[5*i +: 5]     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          wb.req_data_i[32*i +: 32] = $urandom;
        end
      end
      cycle();
    end

    // Reset with entries buffered drops them all.
    rst = 1'b0;
    applyStimulus(3'b111, 5'd4, 5'd5, 5'd6, 32'hB0, 32'hB1, 32'hB2);
    cycle();
    rst = 1'b1;
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    cycle();
    rst = 1'b0;
    chk("midrst_we", 32'(wb.rf_we_o), 32'd0);
    chk("midrst_busy", 32'(wb.busy_o), 32'd0);
    cycle();
    chk("midrst_we2", 32'(wb.rf_we_o), 32'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
